// File: rtl/cp0_exc_sequencer.sv
// cp0_exc_sequencer: arbitrates exceptions, interrupts and eret into CP0 write strobes, pipeline flush and PC redirect
module cp0_exc_sequencer #(
  parameter int NUM_SRC = 4,
  parameter int CODE_W = 5,
  parameter logic [31:0] EXC_VEC = 32'hBFC0_0380
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        exc_req,
  input  logic [NUM_SRC*CODE_W-1:0] exc_code,
  input  logic [NUM_SRC*32-1:0]     exc_pc,
  input  logic [NUM_SRC*32-1:0]     exc_instr,
  input  logic                      irq,
  input  logic                      int_en,
  input  logic [31:0]               int_pc,
  input  logic                      eret,
  input  logic [31:0]               epc_in,
  input  logic                      flush_ack,
  output logic                      busy,
  output logic                      exception_abort,
  output logic                      flush,
  output logic                      badvinstr_we,
  output logic [31:0]               badvinstr_p,
  output logic                      epc_we,
  output logic [31:0]               epc_wdata,
  output logic                      cause_we,
  output logic [CODE_W-1:0]         cause_code,
  output logic                      exl_set,
  output logic                      exl_clr,
  output logic                      redirect_valid,
  output logic [31:0]               redirect_pc
);
  localparam int SW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  typedef enum logic [2:0] {IDLE, CAPTURE, COMMIT, WAIT_ACK, REDIRECT, ERET_S} state_t;
  state_t state, state_n;
  logic kind;
  logic [SW-1:0] sel;
  logic take_exc, take_int, take_eret;
  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (exc_req[i]) sel = SW'(i);
  end
  assign take_exc = state == IDLE && |exc_req;
  assign take_int = state == IDLE && !(|exc_req) && irq && int_en;
  assign take_eret = state == IDLE && !(|exc_req) && !(irq && int_en) && eret;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = (take_exc || take_int) ? CAPTURE : take_eret ? ERET_S : IDLE;
      CAPTURE:  state_n = COMMIT;
      COMMIT:   state_n = WAIT_ACK;
      WAIT_ACK: state_n = flush_ack ? REDIRECT : WAIT_ACK;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      kind <= 1'b0;
      busy <= 1'b0;
      exception_abort <= 1'b0;
      flush <= 1'b0;
      badvinstr_we <= 1'b0;
      badvinstr_p <= '0;
      epc_we <= 1'b0;
      epc_wdata <= '0;
      cause_we <= 1'b0;
      cause_code <= '0;
      exl_set <= 1'b0;
      exl_clr <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
    end else begin
      state <= state_n;
      busy <= state_n != IDLE;
      exception_abort <= state_n == CAPTURE;
      flush <= state_n inside {CAPTURE, COMMIT, WAIT_ACK};
      epc_we <= state_n == COMMIT;
      cause_we <= state_n == COMMIT;
      exl_set <= state_n == COMMIT;
      badvinstr_we <= state_n == COMMIT && kind;
      exl_clr <= state_n == ERET_S;
      redirect_valid <= state_n inside {REDIRECT, ERET_S};
      if (take_exc || take_int) begin
        kind <= take_exc;
        cause_code <= take_exc ? exc_code[sel*CODE_W +: CODE_W] : '0;
        epc_wdata <= take_exc ? exc_pc[sel*32 +: 32] : int_pc;
        badvinstr_p <= take_exc ? exc_instr[sel*32 +: 32] : '0;
      end
      redirect_pc <= take_eret ? epc_in : state_n == REDIRECT ? EXC_VEC : redirect_pc;
    end
  end
endmodule
